// File: rtl/seg_p2s_shifter.sv
// Parallel-to-serial shifter driving a 74HC595-style chain (s_clk / s_data / s_latch).
// Build option: define SEG_P2S_LSB_FIRST_EN to emit par_data[0] first; default is MSB first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, busy=0
// SHIFT_LO | s_clk low, s_data presents the current bit, HALF_DIV cycles
// SHIFT_HI | s_clk high, s_data held, HALF_DIV cycles, then advance bit
// LATCH    | s_latch high, s_clk/s_data low, HALF_DIV cycles
// DONE     | one-cycle done pulse, still busy

module seg_p2s_shifter #(
    parameter int DATA_W   = 64,
    parameter int HALF_DIV = 2,
    parameter int CNT_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] par_data,
    output logic              s_clk,
    output logic              s_data,
    output logic              s_latch,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              s_clk_q, s_clk_d;
    logic              s_data_q, s_data_d;
    logic              s_latch_q, s_latch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_tc;
    logic              out_bit;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        div_tc    = (div_q == '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT_LO;
                    shift_d   = par_data;
                    bit_cnt_d = '0;
                    div_d     = DIV_LOAD;
                end
            end
            SHIFT_LO: begin
                if (div_tc) begin
                    state_d = SHIFT_HI;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_tc) begin
`ifdef SEG_P2S_LSB_FIRST_EN
                    shift_d = shift_q >> 1;
`else
                    shift_d = shift_q << 1;
`endif
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    div_d     = DIV_LOAD;
                    state_d   = (bit_cnt_q == LAST_BIT) ? LATCH : SHIFT_LO;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_tc) begin
                    state_d = DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
`ifdef SEG_P2S_LSB_FIRST_EN
        out_bit = shift_d[0];
`else
        out_bit = shift_d[DATA_W-1];
`endif
        s_clk_d   = (state_d == SHIFT_HI);
        s_data_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? out_bit : 1'b0;
        s_latch_d = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            s_clk_q   <= 1'b0;
            s_data_q  <= 1'b0;
            s_latch_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            s_clk_q   <= s_clk_d;
            s_data_q  <= s_data_d;
            s_latch_q <= s_latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_clk   = s_clk_q;
    assign s_data  = s_data_q;
    assign s_latch = s_latch_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Self-checking bench for seg_p2s_shifter: 8-bit/HALF_DIV=2 instance plus a 1-bit/HALF_DIV=1 instance.
module tb_seg_p2s_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] par_data;
    logic       s_clk, s_data, s_latch, busy, done;

    logic       start1;
    logic [0:0] par_data1;
    logic       s_clk1, s_data1, s_latch1, busy1, done1;

    int checks = 0;
    int errors = 0;

    seg_p2s_shifter #(.DATA_W(8), .HALF_DIV(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .par_data(par_data),
        .s_clk(s_clk), .s_data(s_data), .s_latch(s_latch), .busy(busy), .done(done)
    );

    seg_p2s_shifter #(.DATA_W(1), .HALF_DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .par_data(par_data1),
        .s_clk(s_clk1), .s_data(s_data1), .s_latch(s_latch1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One transfer on the 8-bit instance; optionally pokes start/par_data while busy.
    task automatic run_xfer(input logic [7:0] d, input int poke_lo, input int poke_hi,
                            output logic [7:0] stream, output int nbits, output int busy_cyc,
                            output int done_cnt, output int done_pos, output int latch_cyc,
                            output int bad_latch, output int timed_out);
        logic prev_clk;
        stream = '0; nbits = 0; busy_cyc = 0; done_cnt = 0; done_pos = 0;
        latch_cyc = 0; bad_latch = 0; timed_out = 1; prev_clk = 1'b0;
        @(negedge clk);
        par_data = d;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                timed_out = 0;
                break;
            end
            busy_cyc++;
            if (done) begin
                done_cnt++;
                done_pos = busy_cyc;
            end
            if (s_latch) begin
                latch_cyc++;
                if (s_clk || s_data) bad_latch++;
            end
            if (s_clk && !prev_clk) begin
                stream = {stream[6:0], s_data};
                nbits++;
            end
            prev_clk = s_clk;
            if (busy_cyc == poke_lo) begin
                start    = 1'b1;
                par_data = 8'hFF;
            end
            if (busy_cyc == poke_hi) start = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] stream;
    int nbits, busy_cyc, done_cnt, done_pos, latch_cyc, bad_latch, timed_out;
    logic [7:0] exp_stream;
    logic busy_log[120];
    logic done_log[120];
    int n_done;
    int cyc;
    int sum;

    initial begin
        vecs[0] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{8'hC6, 8'hC6, 8'h63};
        vecs[3] = '{8'h01, 8'h01, 8'h80};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{8'h00, 8'h00, 8'h00};

        rst_n = 1'b0; start = 1'b0; par_data = 8'h00; start1 = 1'b0; par_data1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {s_clk, s_data, s_latch, busy, done}, 0);
        check("reset_outs_1", {s_clk1, s_data1, s_latch1, busy1, done1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven plain transfers
        for (int v = 0; v < 6; v++) begin
`ifdef SEG_P2S_LSB_FIRST_EN
            exp_stream = vecs[v].exp_lsb;
`else
            exp_stream = vecs[v].exp_msb;
`endif
            run_xfer(vecs[v].data, -1, -1, stream, nbits, busy_cyc, done_cnt, done_pos,
                     latch_cyc, bad_latch, timed_out);
            check($sformatf("v%0d_timeout", v), timed_out, 0);
            check($sformatf("v%0d_stream", v), int'(stream), int'(exp_stream));
            check($sformatf("v%0d_nbits", v), nbits, 8);
            check($sformatf("v%0d_busy_cycles", v), busy_cyc, 35);
            check($sformatf("v%0d_done_count", v), done_cnt, 1);
            check($sformatf("v%0d_done_pos", v), done_pos, 35);
            check($sformatf("v%0d_latch_cycles", v), latch_cyc, 2);
            check($sformatf("v%0d_latch_quiet", v), bad_latch, 0);
        end

        // Start re-asserted with new data during bit 3: must be ignored
        run_xfer(8'hA5, 13, 17, stream, nbits, busy_cyc, done_cnt, done_pos,
                 latch_cyc, bad_latch, timed_out);
        check("busy_start_timeout", timed_out, 0);
        check("busy_start_stream", int'(stream), 8'hA5);
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_busy_cycles", busy_cyc, 35);
        repeat (3) @(negedge clk);
        check("busy_start_not_queued", int'(busy), 0);

        // Asynchronous reset during SHIFT_HI of bit 4
        @(negedge clk);
        par_data = 8'hFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 19) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_pre_sclk_high", {s_clk, s_data, busy}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {s_clk, s_data, busy, s_latch, done}, 0);
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sum += int'(s_latch) + int'(done);
        end
        check("rst_no_latch_done", sum, 0);
        rst_n = 1'b1;
        run_xfer(8'h3C, -1, -1, stream, nbits, busy_cyc, done_cnt, done_pos,
                 latch_cyc, bad_latch, timed_out);
        check("post_rst_stream", int'(stream), 8'h3C);
        check("post_rst_done_count", done_cnt, 1);
        check("post_rst_busy_cycles", busy_cyc, 35);

        // start held high: back-to-back transfers with one IDLE cycle
        @(negedge clk);
        par_data = 8'h81;
        start    = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            busy_log[i] = busy;
            done_log[i] = done;
        end
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 118; i++) begin
            if (done_log[i]) begin
                n_done++;
                check($sformatf("b2b_idle_gap_%0d", n_done), int'(busy_log[i+1]), 0);
                check($sformatf("b2b_restart_%0d", n_done), int'(busy_log[i+2]), 1);
            end
        end
        check("b2b_done_count", n_done, 3);
        check("b2b_first_done_idx", int'(done_log[34]), 1);
        timed_out = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 0;
                break;
            end
        end
        check("b2b_drain_timeout", timed_out, 0);

        // DATA_W=1, HALF_DIV=1 instance
        @(negedge clk);
        par_data1 = 1'b1;
        start1    = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_c1_lo", {s_clk1, s_data1, s_latch1, busy1, done1}, 5'b01010);
        @(negedge clk);
        check("w1_c2_hi", {s_clk1, s_data1, s_latch1, busy1, done1}, 5'b11010);
        @(negedge clk);
        check("w1_c3_latch", {s_clk1, s_data1, s_latch1, busy1, done1}, 5'b00110);
        @(negedge clk);
        check("w1_c4_done", {s_clk1, s_data1, s_latch1, busy1, done1}, 5'b00011);
        @(negedge clk);
        check("w1_c5_idle", {s_clk1, s_data1, s_latch1, busy1, done1}, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
